pingpong_rd_packer: RTL
=======================

// Module: pingpong_rd_packer
// PURPOSE
//  Read-side stage directly downstream of the ping-pong async FIFO, in the rclk domain.
//  - Accepts the DATASIZE-wide read stream from the FIFO.
//  - Packs PACK consecutive words into one wide beat.
//  - Presents each beat on a valid/ready output with per-lane keep and a bank-boundary last flag.
//  - Back-pressures the FIFO read side through in_ready.
// PARAMETERS
//  DATASIZE  8   width of one input word (matches FIFO data width)
//  PACK      4   input words per output beat; power of 2, >=2
//  CNT_W     16  width of the saturating output-beat counter
// PORTS
//  rclk       in   1                read-domain clock
//  rst_n      in   1                asynchronous active-low reset
//  in_data    in   DATASIZE         word from FIFO read port
//  in_valid   in   1                in_data valid this cycle
//  in_last    in   1                in_data is the last word of a drained bank
//  in_ready   out  1                packer accepts in_data this cycle
//  flush      in   1                force out a partially filled beat
//  out_data   out  DATASIZE*PACK    packed beat; lane 0 = LSBs = first word accepted
//  out_keep   out  PACK             1 per lane holding valid data
//  out_last   out  1                beat closed by in_last or flush
//  out_valid  out  1                beat valid
//  out_ready  in   1                consumer takes beat when out_valid&out_ready
//  beat_cnt   out  CNT_W            beats delivered; saturates at all-ones
// BEHAVIOUR
//  Reset (async assert, sync release): state=ACC; lane count=0; accumulator=0.
//   Output reset values: out_valid=0, out_data=0, out_keep=0, out_last=0, beat_cnt=0, in_ready=1.
//  Accept: accept = in_valid & in_ready.
//   - Word goes to lane cnt; its keep bit is set; cnt increments.
//  in_ready: depends only on state (1 in ACC, 0 in FULL); no combinational path from out_ready.
//  Completion: a beat closes on the accept cycle when any of these holds:
//   - the word lands in lane PACK-1;
//   - in_last=1;
//   - flush=1 while cnt>0, or flush=1 together with an accept.
//   Lanes above the last filled lane are 0 with keep=0.
//   out_last=1 iff the beat was closed by in_last or flush.
//  Output register is free when !out_valid | out_ready.
//  FSM:
//   - ACC: on completion with output register free -> load output register; cnt=0; stay ACC.
//     On completion with output register not free -> FULL; beat held in accumulator.
//   - FULL: once output register free -> load held beat; cnt=0; go ACC.
//  Latency: out_valid rises 1 rclk after the completing accept (or after the FULL->ACC load).
//  Throughput: one beat per PACK cycles with no stall when out_ready=1.
//  out_valid holds and out_data/keep/last stay stable until out_ready; out_valid drops when the
//   beat is taken and no new beat is loaded in the same cycle.
//  beat_cnt increments on each out_valid&out_ready; holds at 2^CNT_W-1.
//  Boundary rules:
//   - flush with cnt==0 and no accept: ignored.
//   - flush in FULL: ignored; the held beat is already closed.
//   - in_last on lane PACK-1: single full beat, out_last=1.
//   - in_valid without in_ready: word is not consumed; the FIFO must not advance.
//   - rst_n low mid-beat: partial accumulator and any pending output beat are discarded;
//     beat_cnt is cleared.
// STRUCTURE
//  Shared package pingpong_pkg:
//   - state encoding localparams PK_ACC=1'b0, PK_FULL=1'b1;
//   - default DATASIZE and PACK constants used by the FIFO and the packer.
//  One sub-module: pp_out_reg — output register stage with the valid/ready hold logic and
//   beat_cnt. Lane accumulator and FSM stay in the top module.
// TESTING  (DATASIZE=8, PACK=4, CNT_W=16)
//  1. Reset, then in_valid=1 for 4 cycles with 11,22,33,44, out_ready=1
//     -> out_data=0x44332211, keep=4'hF, last=0, out_valid 1 rclk after the 4th accept, beat_cnt=1.
//  2. Words AA,BB,CC with in_last on CC
//     -> out_data=0x00CCBBAA, keep=4'h7, last=1.
//  3. out_ready=0, stream 8 words
//     -> first beat held; second beat completes, in_ready=0 (FULL); nothing lost.
//     Release out_ready -> both beats in order, in_ready=1 after the second load.
//  4. Accept 2 words then flush=1 with no accept
//     -> keep=4'h3, last=1. flush at cnt=0 -> no beat. flush with accept on lane 1 -> keep=4'h3.
//  5. Assert rst_n=0 after 2 words accepted and one beat pending
//     -> out_valid=0, beat_cnt=0 immediately. Next 4 words form a clean beat with keep=4'hF.
//  6. Force beat_cnt to 16'hFFFE, deliver 3 beats -> beat_cnt saturates at 16'hFFFF.

Source files
------------

// File: rtl/pingpong_pkg.sv
// Shared constants for the ping-pong FIFO and its read-side packer.
// Holds the packer state encoding and the default data/pack widths.
package pingpong_pkg;

  localparam logic PK_ACC  = 1'b0;
  localparam logic PK_FULL = 1'b1;

  localparam int DATASIZE_DEF = 8;
  localparam int PACK_DEF     = 4;
  localparam int CNT_W_DEF    = 16;

  typedef enum logic {
    ST_ACC  = PK_ACC,
    ST_FULL = PK_FULL
  } pk_state_e;

endpackage

// File: rtl/pingpong_rd_packer_if.sv
// Read-stream input and packed-beat output of the packer, bundled as one interface.
// The master side is the environment (FIFO + consumer); the slave side is the packer.
interface pingpong_rd_packer_if #(
  parameter int DATASIZE = pingpong_pkg::DATASIZE_DEF,
  parameter int PACK     = pingpong_pkg::PACK_DEF
);

  logic [DATASIZE-1:0]      in_data;
  logic                     in_valid;
  logic                     in_last;
  logic                     in_ready;
  logic                     flush;
  logic [DATASIZE*PACK-1:0] out_data;
  logic [PACK-1:0]          out_keep;
  logic                     out_last;
  logic                     out_valid;
  logic                     out_ready;

  modport master (
    output in_data, in_valid, in_last, flush, out_ready,
    input  in_ready, out_data, out_keep, out_last, out_valid
  );

  modport slave (
    input  in_data, in_valid, in_last, flush, out_ready,
    output in_ready, out_data, out_keep, out_last, out_valid
  );

endinterface

// File: rtl/pp_out_reg.sv
// Output register of the packer: holds a beat until the consumer takes it
// and counts delivered beats with a saturating counter.
module pp_out_reg #(
  parameter int BEAT_W = 32,
  parameter int PACK   = 4,
  parameter int CNT_W  = 16
) (
  input  logic              rclk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [BEAT_W-1:0] load_data,
  input  logic [PACK-1:0]   load_keep,
  input  logic              load_last,
  input  logic              out_ready,
  output logic              out_free,
  output logic [BEAT_W-1:0] out_data,
  output logic [PACK-1:0]   out_keep,
  output logic              out_last,
  output logic              out_valid,
  output logic [CNT_W-1:0]  beat_cnt
);

  logic [CNT_W-1:0] beat_cnt_q;

  assign out_free = !out_valid || out_ready;
  assign beat_cnt = beat_cnt_q;

  always_ff @(posedge rclk or negedge rst_n) begin
    if (!rst_n) begin
      out_data   <= '0;
      out_keep   <= '0;
      out_last   <= 1'b0;
      out_valid  <= 1'b0;
      beat_cnt_q <= '0;
    end else begin
      // Data/keep/last only change on a load, so they stay stable while stalled.
      if (load) begin
        out_data  <= load_data;
        out_keep  <= load_keep;
        out_last  <= load_last;
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      if (out_valid && out_ready && (beat_cnt_q != '1))
        beat_cnt_q <= beat_cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/pingpong_rd_packer.sv
// Packs PACK consecutive FIFO read words into one wide beat with keep/last,
// stalling the FIFO while a closed beat waits for the output register.
module pingpong_rd_packer
  import pingpong_pkg::*;
#(
  parameter int DATASIZE = DATASIZE_DEF,
  parameter int PACK     = PACK_DEF,
  parameter int CNT_W    = CNT_W_DEF
) (
  input  logic              rclk,
  input  logic              rst_n,
  pingpong_rd_packer_if.slave bus,
  output logic [CNT_W-1:0]  beat_cnt
);

  localparam int LANE_W = $clog2(PACK);
  localparam int BEAT_W = DATASIZE * PACK;

  typedef logic [LANE_W-1:0] lane_t;

  pk_state_e         state_q, state_d;
  lane_t             cnt_q, cnt_d;
  logic [BEAT_W-1:0] acc_data_q, acc_data_d, wr_data, load_data;
  logic [PACK-1:0]   acc_keep_q, acc_keep_d, wr_keep, load_keep;
  logic              acc_last_q, acc_last_d, load_last;
  logic              in_ready_c, accept, complete, close_last, out_free, load;

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    state_d    = state_q;
    cnt_d      = cnt_q;
    acc_data_d = acc_data_q;
    acc_keep_d = acc_keep_q;
    acc_last_d = acc_last_q;
    load       = 1'b0;
    load_data  = acc_data_q;
    load_keep  = acc_keep_q;
    load_last  = acc_last_q;

    in_ready_c = (state_q == ST_ACC);
    accept     = bus.in_valid && in_ready_c;

    // Accumulator as it looks with this cycle's word merged into lane cnt.
    wr_data = acc_data_q;
    wr_keep = acc_keep_q;
    if (accept) begin
      wr_data[int'(cnt_q)*DATASIZE +: DATASIZE] = bus.in_data;
      wr_keep[cnt_q]                            = 1'b1;
    end

    complete   = (accept && ((cnt_q == lane_t'(PACK-1)) || bus.in_last || bus.flush))
              || (in_ready_c && bus.flush && (cnt_q != '0));
    close_last = (accept && bus.in_last) || bus.flush;

    case (state_q)
      ST_ACC: begin
        if (complete) begin
          cnt_d = '0;
          if (out_free) begin
            load       = 1'b1;
            load_data  = wr_data;
            load_keep  = wr_keep;
            load_last  = close_last;
            acc_data_d = '0;
            acc_keep_d = '0;
            acc_last_d = 1'b0;
          end else begin
            // Output busy: park the closed beat and stop reading the FIFO.
            state_d    = ST_FULL;
            acc_data_d = wr_data;
            acc_keep_d = wr_keep;
            acc_last_d = close_last;
          end
        end else if (accept) begin
          acc_data_d = wr_data;
          acc_keep_d = wr_keep;
          cnt_d      = cnt_q + lane_t'(1);
        end
      end
      ST_FULL: begin
        if (out_free) begin
          load       = 1'b1;
          acc_data_d = '0;
          acc_keep_d = '0;
          acc_last_d = 1'b0;
          cnt_d      = '0;
          state_d    = ST_ACC;
        end
      end
      default: state_d = ST_ACC;
    endcase
  end

  always_ff @(posedge rclk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the accumulator is reset because unfilled lanes must read as zero in every beat.
      state_q    <= ST_ACC;
      cnt_q      <= '0;
      acc_data_q <= '0;
      acc_keep_q <= '0;
      acc_last_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the same pre-edge values.
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      acc_data_q <= acc_data_d;
      acc_keep_q <= acc_keep_d;
      acc_last_q <= acc_last_d;
    end
  end

  assign bus.in_ready = in_ready_c;

  pp_out_reg #(
    .BEAT_W (BEAT_W),
    .PACK   (PACK),
    .CNT_W  (CNT_W)
  ) u_out (
    .rclk      (rclk),
    .rst_n     (rst_n),
    .load      (load),
    .load_data (load_data),
    .load_keep (load_keep),
    .load_last (load_last),
    .out_ready (bus.out_ready),
    .out_free  (out_free),
    .out_data  (bus.out_data),
    .out_keep  (bus.out_keep),
    .out_last  (bus.out_last),
    .out_valid (bus.out_valid),
    .beat_cnt  (beat_cnt)
  );

endmodule
